// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Summary  : Shared grid geometry, direction codes, cell type and FSM states.
// Revision : 1.0
// ============================================================================
package snake_pkg;

    localparam int CELL_SHIFT = 3;
    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int GRID_CELLS = GRID_W * GRID_H;
    localparam int ADDR_W     = 13;
    localparam int CELL_W     = 13;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
    } cell_t;

    typedef enum logic [3:0] {
        ST_CLEAR     = 4'd0,
        ST_INIT      = 4'd1,
        ST_IDLE      = 4'd2,
        ST_MOVE_CALC = 4'd3,
        ST_CLR_TAIL  = 4'd4,
        ST_CHK       = 4'd5,
        ST_CHK_EVAL  = 4'd6,
        ST_WR_HEAD   = 4'd7,
        ST_GAME_OVER = 4'd8
    } state_t;

    // Row-major bitmap address: y*80 + x.
    function automatic logic [ADDR_W-1:0] cell_addr(input cell_t c);
        return ADDR_W'({c.y, 6'b0}) + ADDR_W'({c.y, 4'b0}) + ADDR_W'(c.x);
    endfunction

    // Opposite directions differ only in bit 1.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : snake_ring_buffer
// Summary  : MAX_LEN-deep FIFO of snake cells; head = newest, tail = oldest.
// Revision : 1.0
// ============================================================================
module snake_ring_buffer
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [CELL_W-1:0]          i_cell,
    output logic [CELL_W-1:0]          o_head,
    output logic [CELL_W-1:0]          o_tail,
    output logic [$clog2(MAX_LEN):0]   o_count
);

    localparam int                  c_PTR_W   = $clog2(MAX_LEN);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]    c_CNT_ONE = 1;

    cell_t              r_mem [MAX_LEN];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W-1:0] w_head_ptr;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= cell_t'(i_cell);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_ptr = r_wr_ptr - c_PTR_ONE;
    assign o_head     = r_mem[w_head_ptr];
    assign o_tail     = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/snake_field_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_field_engine
// Summary  : Snake game state, occupancy bitmap and per-pixel hit flags.
// Revision : 1.0
// ============================================================================
module snake_field_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN     = 64,
    parameter int INIT_LEN    = 4,
    parameter int START_X     = 40,
    parameter int START_Y     = 30,
    parameter int MOVE_FRAMES = 6
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iBLANK_n,
    input  logic       iVS,
    input  logic [1:0] iDIR,
    input  logic       iGROW,
    input  logic       iRESTART,
    output logic       oSNAKE_HIT,
    output logic       oHEAD_HIT,
    output logic       oGAME_OVER,
    output logic [6:0] oLENGTH
);

    localparam int                 c_CNT_W      = $clog2(MAX_LEN) + 1;
    localparam logic [9:0]         c_X_LAST     = 10'd639;
    localparam logic [ADDR_W-1:0]  c_ADDR_LAST  = ADDR_W'(GRID_CELLS - 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE   = 1;
    localparam logic [6:0]         c_LEN_INIT   = 7'(INIT_LEN);
    localparam logic [6:0]         c_INIT_LAST  = 7'(INIT_LEN - 1);
    localparam logic [6:0]         c_INIT_X0    = 7'(START_X - INIT_LEN + 1);
    localparam logic [5:0]         c_INIT_Y     = 6'(START_Y);
    localparam logic [7:0]         c_FRAME_LAST = 8'(MOVE_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(MAX_LEN);

    state_t              r_state;
    logic [9:0]          r_x;
    logic [8:0]          r_y;
    logic                r_vs_d;
    logic [7:0]          r_frame;
    logic [1:0]          r_dir;
    logic                r_grow_pend;
    logic                r_growing;
    cell_t               r_new_head;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [6:0]          r_init_idx;
    logic [6:0]          r_length;
    logic                r_game_over;
    logic                r_snake_hit;
    logic                r_head_hit;
    logic                r_rd_q;
    logic                r_bitmap [GRID_CELLS];

    cell_t               w_scan_cell;
    cell_t               w_init_cell;
    cell_t               w_head;
    cell_t               w_tail;
    cell_t               w_calc_cell;
    cell_t               w_ring_in;
    logic                w_calc_oob;
    logic [c_CNT_W-1:0]  w_ring_count;
    logic                w_full;
    logic                w_show;
    logic [ADDR_W-1:0]   w_fsm_addr;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_we;
    logic                w_wd;

    assign w_scan_cell.x = 7'(r_x >> CELL_SHIFT);
    assign w_scan_cell.y = 6'(r_y >> CELL_SHIFT);
    assign w_init_cell.x = c_INIT_X0 + r_init_idx;
    assign w_init_cell.y = c_INIT_Y;
    assign w_ring_in     = (r_state == ST_INIT) ? w_init_cell : r_new_head;
    assign w_full        = (w_ring_count == c_CNT_MAX);
    assign w_show        = (r_state != ST_CLEAR) && (r_state != ST_INIT) &&
                           (r_state != ST_GAME_OVER);

    snake_ring_buffer #(
        .MAX_LEN (MAX_LEN)
    ) u_ring (
        .clk     (iVGA_CLK),
        .rst_n   (iRST_n),
        .i_clear (r_state == ST_CLEAR),
        .i_push  ((r_state == ST_INIT) || (r_state == ST_WR_HEAD)),
        .i_pop   (r_state == ST_CLR_TAIL),
        .i_cell  (w_ring_in),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_ring_count)
    );

    always_comb begin
        w_calc_cell = w_head;
        w_calc_oob  = 1'b0;
        unique case (r_dir)
            DIR_UP:    if (w_head.y == '0) w_calc_oob = 1'b1;
                       else w_calc_cell.y = w_head.y - 6'd1;
            DIR_RIGHT: if (w_head.x == 7'(GRID_W - 1)) w_calc_oob = 1'b1;
                       else w_calc_cell.x = w_head.x + 7'd1;
            DIR_DOWN:  if (w_head.y == 6'(GRID_H - 1)) w_calc_oob = 1'b1;
                       else w_calc_cell.y = w_head.y + 6'd1;
            DIR_LEFT:  if (w_head.x == '0) w_calc_oob = 1'b1;
                       else w_calc_cell.x = w_head.x - 7'd1;
        endcase
    end

    always_comb begin
        w_fsm_addr = cell_addr(r_new_head);
        w_we       = 1'b0;
        w_wd       = 1'b0;
        case (r_state)
            ST_CLEAR:    begin w_fsm_addr = r_clr_addr; w_we = 1'b1; end
            ST_INIT:     begin w_fsm_addr = cell_addr(w_init_cell); w_we = 1'b1; w_wd = 1'b1; end
            ST_CLR_TAIL: begin w_fsm_addr = cell_addr(w_tail); w_we = 1'b1; end
            ST_WR_HEAD:  begin w_we = 1'b1; w_wd = 1'b1; end
            default:     ;
        endcase
    end

    // Moves only run during vertical blanking, so the scan owns the port in IDLE.
    assign w_addr = (r_state == ST_IDLE) ? cell_addr(w_scan_cell) : w_fsm_addr;

    always_ff @(posedge iVGA_CLK) begin
        if (w_we) r_bitmap[w_addr] <= w_wd;
        r_rd_q <= r_bitmap[w_addr];
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_snake_hit <= 1'b0;
            r_head_hit  <= 1'b0;
        end else begin
            r_snake_hit <= w_show && iBLANK_n && r_bitmap[w_addr];
            r_head_hit  <= w_show && iBLANK_n && (w_scan_cell == w_head);
            if (!iVS) begin
                r_x <= '0;
                r_y <= '0;
            end else if (iBLANK_n) begin
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 9'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state     <= ST_CLEAR;
            r_vs_d      <= 1'b1;
            r_frame     <= '0;
            r_dir       <= DIR_RIGHT;
            r_grow_pend <= 1'b0;
            r_growing   <= 1'b0;
            r_new_head  <= '0;
            r_clr_addr  <= '0;
            r_init_idx  <= '0;
            r_length    <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_vs_d <= iVS;
            if (iGROW && (r_state != ST_CLEAR) && (r_state != ST_INIT)) r_grow_pend <= 1'b1;
            case (r_state)
                ST_CLEAR: begin
                    r_init_idx <= '0;
                    if (r_clr_addr == c_ADDR_LAST) begin
                        r_clr_addr <= '0;
                        r_state    <= ST_INIT;
                    end else begin
                        r_clr_addr <= r_clr_addr + c_ADDR_ONE;
                    end
                end
                ST_INIT: begin
                    if (r_init_idx == c_INIT_LAST) begin
                        r_length <= c_LEN_INIT;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_init_idx <= r_init_idx + 7'd1;
                    end
                end
                ST_IDLE: begin
                    if (!is_reverse(iDIR, r_dir)) r_dir <= iDIR;
                    if (r_vs_d && !iVS) begin
                        if (r_frame == c_FRAME_LAST) begin
                            r_frame <= '0;
                            r_state <= ST_MOVE_CALC;
                        end else begin
                            r_frame <= r_frame + 8'd1;
                        end
                    end
                end
                ST_MOVE_CALC: begin
                    r_new_head <= w_calc_cell;
                    r_growing  <= r_grow_pend && !w_full;
                    if (w_calc_oob) begin
                        r_state     <= ST_GAME_OVER;
                        r_game_over <= 1'b1;
                    end else if (!r_grow_pend || w_full) begin
                        r_state <= ST_CLR_TAIL;
                    end else begin
                        r_state <= ST_CHK;
                    end
                end
                ST_CLR_TAIL: r_state <= ST_CHK;
                ST_CHK:      r_state <= ST_CHK_EVAL;
                ST_CHK_EVAL: begin
                    if (r_rd_q) begin
                        r_state     <= ST_GAME_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= ST_WR_HEAD;
                    end
                end
                ST_WR_HEAD: begin
                    // A pulse landing on the consuming cycle stays pending.
                    if (r_growing) begin
                        r_length <= r_length + 7'd1;
                        if (!iGROW) r_grow_pend <= 1'b0;
                    end
                    r_state <= ST_IDLE;
                end
                ST_GAME_OVER: begin
                    if (iRESTART) begin
                        r_state     <= ST_CLEAR;
                        r_game_over <= 1'b0;
                        r_dir       <= DIR_RIGHT;
                        r_grow_pend <= 1'b0;
                        r_frame     <= '0;
                        r_length    <= '0;
                        r_clr_addr  <= '0;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign oSNAKE_HIT = r_snake_hit;
    assign oHEAD_HIT  = r_head_hit;
    assign oGAME_OVER = r_game_over;
    assign oLENGTH    = r_length;

endmodule
`default_nettype wire

// File: tb/tb_snake_field_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_field_engine
// Summary  : Directed bench for snake_field_engine with hand-derived results.
// Revision : 1.0
// ============================================================================
module tb_snake_field_engine;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       iBLANK_n = 1'b0;
    logic       iVS      = 1'b1;
    logic [1:0] iDIR     = 2'b01;
    logic       iGROW    = 1'b0;
    logic       iRESTART = 1'b0;
    logic       oSNAKE_HIT;
    logic       oHEAD_HIT;
    logic       oGAME_OVER;
    logic [6:0] oLENGTH;

    int n_checks = 0;
    int n_fail   = 0;
    int fc       = 0;

    snake_field_engine dut (
        .iVGA_CLK   (iVGA_CLK),
        .iRST_n     (iRST_n),
        .iBLANK_n   (iBLANK_n),
        .iVS        (iVS),
        .iDIR       (iDIR),
        .iGROW      (iGROW),
        .iRESTART   (iRESTART),
        .oSNAKE_HIT (oSNAKE_HIT),
        .oHEAD_HIT  (oHEAD_HIT),
        .oGAME_OVER (oGAME_OVER),
        .oLENGTH    (oLENGTH)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic vs_fall();
        @(negedge iVGA_CLK); iVS = 1'b0;
        @(negedge iVGA_CLK); iVS = 1'b1;
        repeat (8) @(negedge iVGA_CLK);
        fc = (fc == 5) ? 0 : fc + 1;
    endtask

    task automatic move_step();
        int n;
        n = 6 - fc;
        repeat (n) vs_fall();
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge iVGA_CLK); iDIR = d;
    endtask

    task automatic grow_pulse();
        @(negedge iVGA_CLK); iGROW = 1'b1;
        @(negedge iVGA_CLK); iGROW = 1'b0;
    endtask

    task automatic restart_game();
        @(negedge iVGA_CLK); iRESTART = 1'b1; iDIR = 2'b01;
        @(negedge iVGA_CLK); iRESTART = 1'b0;
        repeat (4820) @(negedge iVGA_CLK);
        fc = 0;
    endtask

    // Present pixel (px,py) after a VS reset of the scan and check the hit flags.
    task automatic scan_pixel(input string tag, input int px, input int py,
                              input logic exp_s, input logic exp_h);
        @(negedge iVGA_CLK); iVS = 1'b0; iBLANK_n = 1'b0;
        @(negedge iVGA_CLK); iVS = 1'b1; iBLANK_n = 1'b1;
        repeat (py * 640 + px + 1) @(negedge iVGA_CLK);
        check_eq({tag, "_snake"}, 32'(oSNAKE_HIT), 32'(exp_s));
        check_eq({tag, "_head"},  32'(oHEAD_HIT),  32'(exp_h));
        iBLANK_n = 1'b0;
        fc = (fc == 5) ? 0 : fc + 1;
    endtask

    initial begin
        repeat (3) @(negedge iVGA_CLK);
        check_eq("rst_len",   32'(oLENGTH),    32'd0);
        check_eq("rst_over",  32'(oGAME_OVER), 32'd0);
        check_eq("rst_snake", 32'(oSNAKE_HIT), 32'd0);
        check_eq("rst_head",  32'(oHEAD_HIT),  32'd0);
        iRST_n = 1'b1;
        repeat (4820) @(negedge iVGA_CLK);
        check_eq("init_len",  32'(oLENGTH),    32'd4);
        check_eq("init_over", 32'(oGAME_OVER), 32'd0);
        scan_pixel("pix00", 0, 0, 1'b0, 1'b0);

        // Right, grow, right, ignored reverse: head ends at (44,30), length 5.
        move_step();
        check_eq("len_move1", 32'(oLENGTH), 32'd4);
        grow_pulse();
        move_step();
        check_eq("len_grow", 32'(oLENGTH), 32'd5);
        move_step();
        check_eq("len_after_grow", 32'(oLENGTH), 32'd5);
        set_dir(2'b11);
        move_step();
        set_dir(2'b00);
        repeat (30) move_step();
        check_eq("len_top", 32'(oLENGTH), 32'd5);
        check_eq("over_top", 32'(oGAME_OVER), 32'd0);
        scan_pixel("c44_0", 352, 0, 1'b1, 1'b1);
        scan_pixel("c44_1", 352, 8, 1'b1, 1'b0);
        scan_pixel("c43_0", 344, 0, 1'b0, 1'b0);

        // Run right along row 0 so the vertical body drains out.
        set_dir(2'b01);
        repeat (5) move_step();
        scan_pixel("c44_0_vac", 352, 0, 1'b0, 1'b0);
        scan_pixel("c45_0",     360, 0, 1'b1, 1'b0);
        scan_pixel("c49_0",     392, 0, 1'b1, 1'b1);
        scan_pixel("c50_0",     400, 0, 1'b0, 1'b0);

        set_dir(2'b00);
        move_step();
        check_eq("over_wall", 32'(oGAME_OVER), 32'd1);
        check_eq("len_wall",  32'(oLENGTH),    32'd5);
        scan_pixel("frozen_gate", 392, 0, 1'b0, 1'b0);

        restart_game();
        check_eq("restart_over", 32'(oGAME_OVER), 32'd0);
        check_eq("restart_len",  32'(oLENGTH),    32'd4);
        scan_pixel("c49_0_clr", 392, 0, 1'b0, 1'b0);

        // Grow to 5 then right, down, left, up runs the head into its own body.
        grow_pulse();
        move_step();
        check_eq("len_grow2", 32'(oLENGTH), 32'd5);
        move_step();
        set_dir(2'b10);
        move_step();
        set_dir(2'b11);
        move_step();
        check_eq("over_before_hit", 32'(oGAME_OVER), 32'd0);
        set_dir(2'b00);
        move_step();
        check_eq("over_self", 32'(oGAME_OVER), 32'd1);
        check_eq("len_self",  32'(oLENGTH),    32'd5);

        restart_game();
        check_eq("restart2_len", 32'(oLENGTH), 32'd4);
        repeat (5) vs_fall();
        @(negedge iVGA_CLK); iVS = 1'b0;
        @(negedge iVGA_CLK); iVS = 1'b1;
        @(negedge iVGA_CLK);
        @(negedge iVGA_CLK);
        check_eq("len_in_chk", 32'(oLENGTH), 32'd4);
        iRST_n = 1'b0;
        #1;
        check_eq("arst_len",   32'(oLENGTH),    32'd0);
        check_eq("arst_over",  32'(oGAME_OVER), 32'd0);
        check_eq("arst_snake", 32'(oSNAKE_HIT), 32'd0);
        check_eq("arst_head",  32'(oHEAD_HIT),  32'd0);
        repeat (2) @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        repeat (4820) @(negedge iVGA_CLK);
        check_eq("rerun_len", 32'(oLENGTH), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
